pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Generates per-stage stall (enable) and clear (flush) controls for the pipeline registers, plus forwarding selects for the ID branch comparator and the EX ALU inputs.
- Owns a latency counter for the multi-cycle multiply/divide unit. It stalls dependent instructions in ID until HI/LO results are ready.

Parameters:
- REG_AW, 5, register-file address width.
- MUL_LAT, 4, multiply busy cycles after issue (≥1).
- DIV_LAT, 32, divide busy cycles after issue (≥1).
- CNT_W, 6, busy-counter width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- rs_d, rt_d  in  REG_AW  source registers of the instruction in ID.
- rs_e, rt_e  in  REG_AW  source registers of the instruction in EX.
- write_reg_e, write_reg_m, write_reg_w  in  REG_AW  destination register per stage.
- reg_write_e, reg_write_m, reg_write_w  in  1  register write enable per stage.
- mem_to_reg_e, mem_to_reg_m  in  1  load instruction in EX / MEM.
- branch_d  in  1  ID instruction compares rs/rt (beq/bne/jr).
- pc_src_d  in  1  branch/jump taken, resolved in ID.
- md_start_e  in  1  mul/div instruction in EX issues this cycle.
- md_div_e  in  1  issuing op is a divide (else multiply).
- md_use_d  in  1  ID instruction reads HI/LO or is itself a mul/div.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID.
- flush_d  out  1  clear IF/ID.
- flush_e  out  1  clear ID/EX (bubble).
- fwd_a_d, fwd_b_d  out  1  ID comparator operand from EX/MEM ALU result.
- fwd_a_e, fwd_b_e  out  2  EX operand select: 00 regfile, 01 WB result, 10 MEM ALU result.
- md_busy  out  1  mul/div unit occupied.
- md_done  out  1  one-cycle pulse on the final busy cycle.

Behaviour:
- **Reset.** While reset==0 at a clock edge: FSM→IDLE, count→0. Outputs during reset-low cycles are forced: stall_f=stall_d=0, flush_d=flush_e=1, all fwd=0, md_busy=md_done=0. A reset arriving mid-operation abandons the busy count immediately.
- **Forwarding (combinational).** Register 0 never matches.
  - fwd_a_e=10 when reg_write_m && write_reg_m==rs_e; else 01 when reg_write_w && write_reg_w==rs_e; else 00. MEM takes priority over WB.
  - fwd_b_e uses the same rule with rt_e.
  - fwd_a_d=1 iff reg_write_m && write_reg_m==rs_d; fwd_b_d likewise with rt_d.
- **Load-use stall.** lw_stall = mem_to_reg_e && write_reg_e!=0 && (write_reg_e==rs_d || write_reg_e==rt_d).
- **Branch stall.** br_stall = branch_d && one of:
  - reg_write_e && write_reg_e∈{rs_d,rt_d}, or
  - mem_to_reg_m && write_reg_m∈{rs_d,rt_d}.
  - In both cases write_reg≠0.
- **Multiply/divide FSM.** States IDLE, BUSY.
  - IDLE: md_start_e=1 → BUSY; count loads DIV_LAT if md_div_e, else MUL_LAT.
  - BUSY: count decrements each cycle. When count==1 → IDLE with count=0.
  - md_start_e while BUSY is ignored; no reload.
  - md_busy = (state==BUSY), registered. md_done = BUSY && count==1.
  - Result: md_busy is high for exactly LAT cycles, starting the cycle after the issue edge.
- **MD stall.** md_stall = md_use_d && (md_busy && !md_done || md_start_e).
  - md_done releases the stall one cycle early, because HI/LO are written at the end of that cycle.
- **Combined outputs.**
  - stall = lw_stall | br_stall | md_stall.
  - stall_f = stall_d = stall.
  - flush_e = stall.
  - flush_d = pc_src_d && !stall. A stall takes priority: a taken branch is not acted on until its operands are valid.
- **Latency.** All outputs except md_busy/md_done are combinational, with zero latency.

Decomposition:
- **Shared package:** FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; FSM state encoding MD_IDLE/MD_BUSY; REG_AW default.
- **Sub-module md_busy_cnt** (FSM + counter, md_busy/md_done). All other logic stays in the top level.

Test Plan:
- **MEM/WB forwarding.** reg_write_m=1, write_reg_m=8, reg_write_w=1, write_reg_w=8, rs_e=8, rt_e=9 → fwd_a_e=10, fwd_b_e=00. Then reg_write_m=0 → fwd_a_e=01. With rs_e=0 → fwd 00 regardless of writes.
- **Load-use.** mem_to_reg_e=1, write_reg_e=5, rt_d=5 → stall_f=stall_d=flush_e=1 for one cycle. Next cycle, with the load in MEM → stall 0, fwd_b_e=01 after one more cycle.
- **Branch dependency and taken branch.** branch_d=1, rs_d=3, reg_write_e=1, write_reg_e=3, pc_src_d=1 → stall=1, flush_d=0. With the producer in MEM (reg_write_m, not a load) → stall=0, fwd_a_d=1, flush_d=1.
- **Divide latency.** md_start_e=1, md_div_e=1 at edge T → md_busy high cycles T+1..T+32, md_done high at T+32 only. With md_use_d=1 throughout → stall high from T through T+31, low at T+32.
- **Multiply issue ignored while busy.** MUL_LAT=4: a second md_start_e during BUSY leaves the busy window at 4 cycles.
- **Reset mid-operation.** reset=0 at cycle 10 of a divide → next cycle md_busy=0, count=0; during reset flush_d=flush_e=1, stalls 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_pkg
//  Description : Shared encodings for the pipeline hazard controller:
//                forwarding selects, mul/div FSM states and a register
//                dependency helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  localparam int REG_AW_DEFAULT = 5;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // A producer hits a source register when it writes, targets the same
  // register, and that register is not the hardwired zero register.
  function automatic logic reg_hit(
    input logic                      we,
    input logic [REG_AW_DEFAULT-1:0] wr,
    input logic [REG_AW_DEFAULT-1:0] src
  );
    return we && (wr != '0) && (wr == src);
  endfunction

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_md_busy_cnt
//  Description : Multiply/divide occupancy tracker. Loads the op latency on
//                issue and counts down; busy is high for exactly LAT cycles
//                following the issue edge, done pulses on the last of them.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl_md_busy_cnt
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy,
  output logic md_done
);

  localparam logic [CNT_W-1:0] c_mul_lat = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] c_div_lat = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  // State and countdown registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= MD_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next state: issue only from IDLE, a new start while busy is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      MD_IDLE: begin
        if (md_start) begin
          w_state_nxt = MD_BUSY;
          w_count_nxt = md_div ? c_div_lat : c_mul_lat;
        end
      end
      MD_BUSY: begin
        if (r_count == c_one) begin
          w_state_nxt = MD_IDLE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count - c_one;
        end
      end
      default: begin
        w_state_nxt = MD_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  assign md_busy = (r_state == MD_BUSY);
  assign md_done = (r_state == MD_BUSY) && (r_count == c_one);

endmodule : pipe_hazard_ctrl_md_busy_cnt
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard controller for a 5-stage pipeline: stall/flush of the
//                pipeline registers, ID and EX forwarding selects, and
//                HI/LO dependency stalls against the multi-cycle mul/div.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEFAULT,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] write_reg_e,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic [REG_AW-1:0] write_reg_w,
  input  logic              reg_write_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              mem_to_reg_e,
  input  logic              mem_to_reg_m,
  input  logic              branch_d,
  input  logic              pc_src_d,
  input  logic              md_start_e,
  input  logic              md_div_e,
  input  logic              md_use_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              md_busy,
  output logic              md_done
);

  logic       w_md_busy;
  logic       w_md_done;
  logic       w_lw_stall;
  logic       w_br_stall;
  logic       w_md_stall;
  logic       w_stall;
  logic [1:0] w_fwd_a_e;
  logic [1:0] w_fwd_b_e;

  pipe_hazard_ctrl_md_busy_cnt #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start_e),
    .md_div   (md_div_e),
    .md_busy  (w_md_busy),
    .md_done  (w_md_done)
  );

  // EX operand selection: the younger MEM result wins over WB.
  always_comb begin
    w_fwd_a_e = FWD_RF;
    w_fwd_b_e = FWD_RF;
    if (reg_hit(reg_write_m, write_reg_m, rs_e))      w_fwd_a_e = FWD_MEM;
    else if (reg_hit(reg_write_w, write_reg_w, rs_e)) w_fwd_a_e = FWD_WB;
    if (reg_hit(reg_write_m, write_reg_m, rt_e))      w_fwd_b_e = FWD_MEM;
    else if (reg_hit(reg_write_w, write_reg_w, rt_e)) w_fwd_b_e = FWD_WB;
  end

  // Stall sources: load-use, branch operands not yet available, HI/LO busy.
  always_comb begin
    w_lw_stall = reg_hit(mem_to_reg_e, write_reg_e, rs_d) ||
                 reg_hit(mem_to_reg_e, write_reg_e, rt_d);
    w_br_stall = branch_d &&
                 (reg_hit(reg_write_e,  write_reg_e, rs_d) ||
                  reg_hit(reg_write_e,  write_reg_e, rt_d) ||
                  reg_hit(mem_to_reg_m, write_reg_m, rs_d) ||
                  reg_hit(mem_to_reg_m, write_reg_m, rt_d));
    // md_done releases early: HI/LO are written at the end of that cycle.
    w_md_stall = md_use_d && ((w_md_busy && !w_md_done) || md_start_e);
    w_stall    = w_lw_stall || w_br_stall || w_md_stall;
  end

  // Output drive; while reset is low the pipeline is held cleared.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b1;
    flush_e = 1'b1;
    fwd_a_d = 1'b0;
    fwd_b_d = 1'b0;
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    md_busy = 1'b0;
    md_done = 1'b0;
    if (reset) begin
      stall_f = w_stall;
      stall_d = w_stall;
      flush_e = w_stall;
      // A taken branch waits until its operands are valid.
      flush_d = pc_src_d && !w_stall;
      fwd_a_d = reg_hit(reg_write_m, write_reg_m, rs_d);
      fwd_b_d = reg_hit(reg_write_m, write_reg_m, rt_d);
      fwd_a_e = w_fwd_a_e;
      fwd_b_e = w_fwd_b_e;
      md_busy = w_md_busy;
      md_done = w_md_done;
    end
  end

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//                with literal expectations plus randomized traffic compared
//                every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int AW  = 5;
  localparam int MUL = 4;
  localparam int DIV = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rs_d, rt_d, rs_e, rt_e;
  logic [AW-1:0] write_reg_e, write_reg_m, write_reg_w;
  logic          reg_write_e, reg_write_m, reg_write_w;
  logic          mem_to_reg_e, mem_to_reg_m;
  logic          branch_d, pc_src_d;
  logic          md_start_e, md_div_e, md_use_d;
  logic          stall_f, stall_d, flush_d, flush_e;
  logic          fwd_a_d, fwd_b_d;
  logic [1:0]    fwd_a_e, fwd_b_e;
  logic          md_busy, md_done;

  int checks   = 0;
  int failures = 0;
  int md_left  = 0;   // model: busy cycles still to come

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW (AW), .MUL_LAT (MUL), .DIV_LAT (DIV), .CNT_W (6)
  ) dut (
    .clk (clk), .reset (reset),
    .rs_d (rs_d), .rt_d (rt_d), .rs_e (rs_e), .rt_e (rt_e),
    .write_reg_e (write_reg_e), .write_reg_m (write_reg_m), .write_reg_w (write_reg_w),
    .reg_write_e (reg_write_e), .reg_write_m (reg_write_m), .reg_write_w (reg_write_w),
    .mem_to_reg_e (mem_to_reg_e), .mem_to_reg_m (mem_to_reg_m),
    .branch_d (branch_d), .pc_src_d (pc_src_d),
    .md_start_e (md_start_e), .md_div_e (md_div_e), .md_use_d (md_use_d),
    .stall_f (stall_f), .stall_d (stall_d), .flush_d (flush_d), .flush_e (flush_e),
    .fwd_a_d (fwd_a_d), .fwd_b_d (fwd_b_d), .fwd_a_e (fwd_a_e), .fwd_b_e (fwd_b_e),
    .md_busy (md_busy), .md_done (md_done)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: does a writing stage supply register src (r0 is never produced)?
  function automatic bit writes(input bit we, input int wr, input int src);
    return we && wr != 0 && wr == src;
  endfunction

  // Model of the mul/div unit: busy for LAT cycles after an accepted issue.
  always @(posedge clk) begin
    if (!reset)          md_left <= 0;
    else if (md_left > 0) md_left <= md_left - 1;
    else if (md_start_e)  md_left <= md_div_e ? DIV : MUL;
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit busy, done, need_d, stall, lw, br;
    int ea, eb;
    busy = reset && md_left > 0;
    done = reset && md_left == 1;
    lw = writes(mem_to_reg_e, write_reg_e, rs_d) || writes(mem_to_reg_e, write_reg_e, rt_d);
    br = branch_d && (writes(reg_write_e, write_reg_e, rs_d) || writes(reg_write_e, write_reg_e, rt_d) ||
                      writes(mem_to_reg_m, write_reg_m, rs_d) || writes(mem_to_reg_m, write_reg_m, rt_d));
    need_d = md_use_d && ((md_left > 1) || md_start_e);
    stall = reset && (lw || br || need_d);
    ea = !reset ? 0 : writes(reg_write_m, write_reg_m, rs_e) ? 2 : writes(reg_write_w, write_reg_w, rs_e) ? 1 : 0;
    eb = !reset ? 0 : writes(reg_write_m, write_reg_m, rt_e) ? 2 : writes(reg_write_w, write_reg_w, rt_e) ? 1 : 0;
    check("m_stall_f", stall_f, stall);
    check("m_stall_d", stall_d, stall);
    check("m_flush_e", flush_e, reset ? stall : 1);
    check("m_flush_d", flush_d, reset ? (pc_src_d && !stall) : 1);
    check("m_fwd_a_d", fwd_a_d, reset && writes(reg_write_m, write_reg_m, rs_d));
    check("m_fwd_b_d", fwd_b_d, reset && writes(reg_write_m, write_reg_m, rt_d));
    check("m_fwd_a_e", fwd_a_e, ea);
    check("m_fwd_b_e", fwd_b_e, eb);
    check("m_md_busy", md_busy, busy);
    check("m_md_done", md_done, done);
  end

  task automatic clear_inputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    write_reg_e = '0; write_reg_m = '0; write_reg_w = '0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0;
    branch_d = 0; pc_src_d = 0;
    md_start_e = 0; md_div_e = 0; md_use_d = 0;
  endtask

  // Advance to the next drive point (just after the rising edge).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    int busy_n, done_n, stall_n, done_idx;
    clear_inputs();
    reset = 0;
    md_start_e = 1; md_div_e = 1;   // must be ignored while in reset
    next_cycle();
    sample();
    check("rst_flush_d", flush_d, 1);
    check("rst_flush_e", flush_e, 1);
    check("rst_stall_f", stall_f, 0);
    check("rst_busy", md_busy, 0);
    next_cycle();
    clear_inputs();
    reset = 1;
    next_cycle();
    sample();
    check("post_rst_busy", md_busy, 0);

    // Forwarding: MEM over WB, WB alone, register zero never forwards.
    next_cycle();
    reg_write_m = 1; write_reg_m = 8; reg_write_w = 1; write_reg_w = 8;
    rs_e = 8; rt_e = 9;
    sample();
    check("fwd_mem_a", fwd_a_e, 2);
    check("fwd_mem_b", fwd_b_e, 0);
    next_cycle();
    reg_write_m = 0;
    sample();
    check("fwd_wb_a", fwd_a_e, 1);
    next_cycle();
    reg_write_m = 1; write_reg_m = 0; write_reg_w = 0; rs_e = 0;
    sample();
    check("fwd_r0", fwd_a_e, 0);

    // Load-use: one stall cycle, then forwarded from WB.
    next_cycle();
    clear_inputs();
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5; rt_d = 5;
    sample();
    check("lw_stall", stall_d, 1);
    check("lw_flush_e", flush_e, 1);
    next_cycle();
    clear_inputs();
    mem_to_reg_m = 1; reg_write_m = 1; write_reg_m = 5; rt_d = 5;
    sample();
    check("lw_release", stall_f, 0);
    next_cycle();
    clear_inputs();
    reg_write_w = 1; write_reg_w = 5; rt_e = 5;
    sample();
    check("lw_fwd_wb", fwd_b_e, 1);

    // Branch dependent on EX producer, then forwarded from MEM.
    next_cycle();
    clear_inputs();
    branch_d = 1; pc_src_d = 1; rs_d = 3; reg_write_e = 1; write_reg_e = 3;
    sample();
    check("br_stall", stall_f, 1);
    check("br_no_flush", flush_d, 0);
    next_cycle();
    reg_write_e = 0; write_reg_e = 0; reg_write_m = 1; write_reg_m = 3;
    sample();
    check("br_release", stall_f, 0);
    check("br_fwd_a_d", fwd_a_d, 1);
    check("br_flush_d", flush_d, 1);

    // Divide latency with a dependent instruction held in ID.
    next_cycle();
    clear_inputs();
    md_start_e = 1; md_div_e = 1; md_use_d = 1;
    sample();
    check("div_issue_stall", stall_f, 1);
    next_cycle();
    md_start_e = 0; md_div_e = 0;
    busy_n = 0; done_n = 0; stall_n = 0; done_idx = -1;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (md_busy) busy_n++;
      if (md_done) begin done_n++; done_idx = i; end
      if (stall_f) stall_n++;
      next_cycle();
    end
    check("div_busy_cycles", busy_n, 32);
    check("div_done_pulses", done_n, 1);
    check("div_done_index", done_idx, 31);
    check("div_stall_cycles", stall_n, 31);

    // Multiply with a second issue while busy: window stays 4 cycles.
    clear_inputs();
    md_start_e = 1;
    next_cycle();
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      md_start_e = (i == 1);
      sample();
      if (md_busy) busy_n++;
      next_cycle();
    end
    check("mul_busy_cycles", busy_n, 4);

    // Reset in the middle of a divide.
    clear_inputs();
    md_start_e = 1; md_div_e = 1;
    next_cycle();
    clear_inputs();
    repeat (10) next_cycle();
    reset = 0; pc_src_d = 1; md_use_d = 1;
    sample();
    check("mid_rst_busy_pre", md_busy, 0);
    check("mid_rst_flush_d", flush_d, 1);
    check("mid_rst_flush_e", flush_e, 1);
    check("mid_rst_stall", stall_d, 0);
    next_cycle();
    reset = 1; clear_inputs();
    sample();
    check("mid_rst_busy_post", md_busy, 0);

    // Randomized traffic; register fields kept narrow so hazards are common.
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      reset        = ($urandom_range(0, 99) != 0);
      rs_d         = AW'($urandom_range(0, 3));
      rt_d         = AW'($urandom_range(0, 3));
      rs_e         = AW'($urandom_range(0, 3));
      rt_e         = AW'($urandom_range(0, 3));
      write_reg_e  = AW'($urandom_range(0, 3));
      write_reg_m  = AW'($urandom_range(0, 3));
      write_reg_w  = AW'($urandom_range(0, 3));
      reg_write_e  = 1'($urandom);
      reg_write_m  = 1'($urandom);
      reg_write_w  = 1'($urandom);
      mem_to_reg_e = ($urandom_range(0, 3) == 0);
      mem_to_reg_m = ($urandom_range(0, 3) == 0);
      branch_d     = ($urandom_range(0, 2) == 0);
      pc_src_d     = 1'($urandom);
      md_start_e   = ($urandom_range(0, 7) == 0);
      md_div_e     = ($urandom_range(0, 3) == 0);
      md_use_d     = 1'($urandom);
    end
    next_cycle();
    sample();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
